// File: rtl/seq_shift_add_mul_16_pkg.sv
// rtl/seq_shift_add_mul_16_pkg.sv - shared constants and state encoding for the shift-add multiplier
package seq_shift_add_mul_16_pkg;
   localparam int MUL_WIDTH = 16;
   localparam int CNT_W     = $clog2(MUL_WIDTH) + 1;
   localparam logic [CNT_W-1:0] MUL_ITER_LAST = CNT_W'(MUL_WIDTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/seq_shift_add_mul_16_cla.sv
// rtl/seq_shift_add_mul_16_cla.sv - 16-bit carry-lookahead adder, four 4-bit groups joined by a lookahead unit
module CLA_16_bit_LCU (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] s,
   output logic        c_out,
   output logic        p,
   output logic        g
);
   logic [15:0] bp;
   logic [15:0] bg;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [4:0]  cb;
   logic        cr;

   always_comb begin
      bp = a ^ b;
      bg = a & b;
      for (int j = 0; j < 4; j++) begin
         gp[j] = &bp[4*j +: 4];
         gg[j] = bg[4*j+3]
               | (bp[4*j+3] & bg[4*j+2])
               | (bp[4*j+3] & bp[4*j+2] & bg[4*j+1])
               | (bp[4*j+3] & bp[4*j+2] & bp[4*j+1] & bg[4*j]);
      end
      // group carries come from the lookahead unit, bit carries ripple inside a group
      cr = c_in;
      for (int j = 0; j < 4; j++) begin
         cb[j] = cr;
         cr = gg[j] | (gp[j] & cr);
      end
      cb[4] = cr;
      cr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0) cr = cb[i/4];
         s[i] = bp[i] ^ cr;
         cr = bg[i] | (bp[i] & cr);
      end
      c_out = cb[4];
      p = &gp;
      g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
   end
endmodule

// File: rtl/seq_shift_add_mul_16.sv
// rtl/seq_shift_add_mul_16.sv - sequential 16x16->32 shift-and-add multiplier, one CLA iteration per clock
// Optional MUL_ZERO_BYPASS_EN: zero operands complete in one cycle without entering RUN.
module seq_shift_add_mul_16
   import seq_shift_add_mul_16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);
   state_t           state;
   logic [CNT_W-1:0] count;
   logic [31:0]      p_reg;
   logic [15:0]      mcand;
   logic [15:0]      addend;
   logic [15:0]      sum;
   logic             c;
   logic [31:0]      p_next;
   logic             cla_p_unused;
   logic             cla_g_unused;

   assign addend = p_reg[0] ? mcand : 16'd0;

   CLA_16_bit_LCU u_cla (
      .a     (p_reg[31:16]),
      .b     (addend),
      .c_in  (1'b0),
      .s     (sum),
      .c_out (c),
      .p     (cla_p_unused),
      .g     (cla_g_unused)
   );

   // carry-out becomes the top bit of the shifted partial product
   assign p_next = {c, sum, p_reg[15:1]};
   assign busy   = (state == S_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         count   <= '0;
         p_reg   <= '0;
         mcand   <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
`ifdef MUL_ZERO_BYPASS_EN
                  if (a == 16'd0 || b == 16'd0) begin
                     product <= '0;
                     done    <= 1'b1;
                  end else begin
                     mcand <= a;
                     p_reg <= {16'd0, b};
                     count <= '0;
                     state <= S_RUN;
                  end
`else
                  mcand <= a;
                  p_reg <= {16'd0, b};
                  count <= '0;
                  state <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               p_reg <= p_next;
               count <= count + 1'b1;
               if (count == MUL_ITER_LAST) begin
                  product <= p_next;
                  done    <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_shift_add_mul_16.sv
// tb/tb_seq_shift_add_mul_16.sv - directed scoreboard bench for the shift-add multiplier
module tb_seq_shift_add_mul_16;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int          total = 0;
   int          bad = 0;
   logic [31:0] sb[$];

`ifdef MUL_ZERO_BYPASS_EN
   localparam int ZERO_LAT = 0;
`else
   localparam int ZERO_LAT = 16;
`endif

   always #5 clk = ~clk;

   seq_shift_add_mul_16 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) chk("done_while_busy", {31'd0, busy}, 32'd0);
   end

   task automatic launch(input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      sb.push_back(32'(x) * 32'(y));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
      int lat = 0;
      int busy_n = 0;
      logic [31:0] e;
      while (1) begin
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1 || lat >= 40) break;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_seen"}, {31'd0, done}, 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({tag, "_prod"}, product, e);
         end
      end
   endtask

   task automatic after_done(input string tag, input logic [31:0] exp);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_hold"}, product, exp);
   endtask

   initial begin
      int dn;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_prod", product, 32'd0);
      rst = 1'b0;

      launch(16'd32445, 16'd16785);
      wait_done("t1", 16, 16);
      after_done("t1", 32'd544589325);

      launch(16'hFFFF, 16'hFFFF);
      wait_done("t2", 16, 16);
      after_done("t2", 32'hFFFE0001);

      launch(16'd0, 16'd12345);
      wait_done("t3", ZERO_LAT, ZERO_LAT);
      after_done("t3", 32'd0);

      launch(16'd3, 16'd5);
      repeat (3) @(negedge clk);
      a = 16'd7;
      b = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t4", 12, 12);
      after_done("t4", 32'd15);

      launch(16'd1000, 16'd1000);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_done", {31'd0, done}, 32'd0);
      chk("t5_rst_prod", product, 32'd0);
      void'(sb.pop_back());
      dn = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      chk("t5_no_done", 32'(dn), 32'd0);
      launch(16'd12500, 16'd40535);
      wait_done("t5b", 16, 16);
      after_done("t5b", 32'd506687500);

      @(negedge clk);
      a = 16'd2;
      b = 16'd3;
      start = 1'b1;
      sb.push_back(32'd6);
      @(negedge clk);
      a = 16'd4;
      b = 16'd5;
      wait_done("t6a", 16, 16);
      sb.push_back(32'd20);
      @(negedge clk);
      start = 1'b0;
      chk("t6_pulse", {31'd0, done}, 32'd0);
      chk("t6_busy_rise", {31'd0, busy}, 32'd1);
      chk("t6_hold", product, 32'd6);
      wait_done("t6b", 16, 16);
      after_done("t6b", 32'd20);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
